// File: rtl/shop_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shop_pkg
// Description : Shared state encoding, default widths and saturating adder
//               for the shop checkout block.
// Revision    : 1.0 - initial release
// ============================================================================
package shop_pkg;

  localparam int DEF_W_WIDTH   = 4;
  localparam int DEF_P_WIDTH   = 4;
  localparam int DEF_SUB_WIDTH = 12;
  localparam int DEF_SUM_WIDTH = 16;
  localparam int DEF_CNT_WIDTH = 8;

  // Checkout state encoding (also visible on the state output).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPEN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Saturating unsigned add clamped to a field of 'width' bits (width <= 32).
  // Bit 32 of the result flags that the clamp was applied.
  function automatic logic [32:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] full;
    logic [32:0] lim;
    full = {1'b0, a} + {1'b0, b};
    lim  = (33'd1 << width) - 33'd1;
    if (full > lim) begin
      sat_add = {1'b1, lim[31:0]};
    end else begin
      sat_add = {1'b0, full[31:0]};
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_rise.sv
`default_nettype none
// ============================================================================
// Module      : edge_rise
// Description : One-cycle rising-edge detector for a level input. After reset
//               the input must be seen low once before a rise is reported, so
//               a level held high across reset release never fires.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_rise (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic prev;
  logic armed;

  // Track the previous level and whether a low level has been seen since reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev  <= d;
      armed <= armed | ~d;
    end
  end

  assign pulse = d & ~prev & armed;

endmodule
`default_nettype wire

// File: rtl/shop_checkout.sv
`default_nettype none
// ============================================================================
// Module      : shop_checkout
// Description : Checkout register: per-item pricing, running transaction
//               subtotal with single-level undo, grand total and counters,
//               all saturating with a sticky overflow flag.
//               The "void" request port is named void_item because "void" is
//               a reserved word in SystemVerilog.
// Revision    : 1.0 - initial release
// ============================================================================
module shop_checkout
  import shop_pkg::*;
#(
  parameter int W_WIDTH   = DEF_W_WIDTH,
  parameter int P_WIDTH   = DEF_P_WIDTH,
  parameter int SUB_WIDTH = DEF_SUB_WIDTH,
  parameter int SUM_WIDTH = DEF_SUM_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [W_WIDTH-1:0]         weight,
  input  logic [P_WIDTH-1:0]         per,
  input  logic                       add,
  input  logic                       void_item,
  input  logic                       checkout,
  input  logic                       clear,
  output logic [W_WIDTH+P_WIDTH-1:0] price,
  output logic [SUB_WIDTH-1:0]       subtotal,
  output logic [CNT_WIDTH-1:0]       items,
  output logic [CNT_WIDTH-1:0]       times,
  output logic [SUM_WIDTH-1:0]       sum,
  output logic [1:0]                 state,
  output logic                       ovf
);

  localparam int PR_WIDTH = W_WIDTH + P_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t st;
  state_t st_nxt;

  logic                add_p;
  logic                void_p;
  logic                chk_p;
  logic                ev_clr;
  logic                ev_chk;
  logic                ev_void;
  logic                ev_add;
  logic                do_close;
  logic                do_undo;
  logic                do_add;
  logic                void_ok;
  logic [PR_WIDTH-1:0] last;
  logic [PR_WIDTH-1:0] prod;

  logic [SUB_WIDTH-1:0] sub_base;
  logic [CNT_WIDTH-1:0] items_base;
  logic [32:0]          sub_sum_r;
  logic [32:0]          items_inc_r;
  logic [32:0]          times_inc_r;
  logic [32:0]          sum_add_r;
  logic [31:0]          sub32;
  logic [31:0]          last32;
  logic [31:0]          sub_diff;
  logic                 unused_hi;

  // Edge detectors for the three level-sensitive requests.
  edge_rise u_add_edge (
    .clk   (clk),
    .reset (reset),
    .d     (add),
    .pulse (add_p)
  );

  edge_rise u_void_edge (
    .clk   (clk),
    .reset (reset),
    .d     (void_item),
    .pulse (void_p)
  );

  edge_rise u_chk_edge (
    .clk   (clk),
    .reset (reset),
    .d     (checkout),
    .pulse (chk_p)
  );

  // Full-width item price from the inputs of the current cycle.
  assign prod = {{P_WIDTH{1'b0}}, weight} * {{W_WIDTH{1'b0}}, per};

  // Priority: clear > checkout > void > add. Any higher-priority edge present
  // in a cycle swallows the lower ones, even when it is itself not applicable.
  assign ev_clr  = clear;
  assign ev_chk  = ~clear & chk_p;
  assign ev_void = ~clear & ~chk_p & void_p;
  assign ev_add  = ~clear & ~chk_p & ~void_p & add_p;

  // A new transaction starts from zero; an open one accumulates.
  assign sub_base   = (st == ST_OPEN) ? subtotal : '0;
  assign items_base = (st == ST_OPEN) ? items    : '0;

  assign sub_sum_r   = sat_add(32'(sub_base),   32'(prod),     SUB_WIDTH);
  assign items_inc_r = sat_add(32'(items_base), 32'd1,         CNT_WIDTH);
  assign times_inc_r = sat_add(32'(times),      32'd1,         CNT_WIDTH);
  assign sum_add_r   = sat_add(32'(sum),        32'(subtotal), SUM_WIDTH);

  // Undo subtracts the exact last price and floors at zero (it may have been
  // clipped by a saturated add).
  assign sub32    = 32'(subtotal);
  assign last32   = 32'(last);
  assign sub_diff = (sub32 >= last32) ? (sub32 - last32) : 32'd0;

  // Upper bits of the 32-bit helper results are always zero here.
  assign unused_hi = ^{sub_sum_r[31:SUB_WIDTH], items_inc_r[31:CNT_WIDTH],
                       times_inc_r[31:CNT_WIDTH], sum_add_r[31:SUM_WIDTH],
                       sub_diff[31:SUB_WIDTH]};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= ST_IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    st_nxt = st;
    if (ev_clr) begin
      st_nxt = ST_IDLE;
    end else if (do_close) begin
      st_nxt = ST_DONE;
    end else if (do_undo) begin
      if (items == CNT_ONE) begin
        st_nxt = ST_IDLE;
      end
    end else if (do_add) begin
      st_nxt = ST_OPEN;
    end
  end

  // Output decode: state code and the datapath actions allowed in this state.
  always_comb begin
    state    = st;
    do_close = ev_chk & (st == ST_OPEN);
    do_undo  = ev_void & (st == ST_OPEN) & void_ok;
    do_add   = ev_add;
  end

  // Datapath registers: price pipeline, transaction and grand totals.
  always_ff @(posedge clk) begin
    if (reset) begin
      price    <= '0;
      subtotal <= '0;
      items    <= '0;
      times    <= '0;
      sum      <= '0;
      ovf      <= 1'b0;
      last     <= '0;
      void_ok  <= 1'b0;
    end else begin
      price <= prod;
      if (ev_clr) begin
        subtotal <= '0;
        items    <= '0;
        times    <= '0;
        sum      <= '0;
        ovf      <= 1'b0;
        void_ok  <= 1'b0;
      end else if (do_close) begin
        sum   <= sum_add_r[SUM_WIDTH-1:0];
        times <= times_inc_r[CNT_WIDTH-1:0];
        ovf   <= ovf | sum_add_r[32] | times_inc_r[32];
      end else if (do_undo) begin
        subtotal <= sub_diff[SUB_WIDTH-1:0];
        items    <= items - CNT_ONE;
        void_ok  <= 1'b0;
      end else if (do_add) begin
        subtotal <= sub_sum_r[SUB_WIDTH-1:0];
        items    <= items_inc_r[CNT_WIDTH-1:0];
        last     <= prod;
        void_ok  <= 1'b1;
        ovf      <= ovf | sub_sum_r[32] | items_inc_r[32];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shop_checkout.sv
`default_nettype none
// ============================================================================
// Module      : tb_shop_checkout
// Description : Self-checking bench for shop_checkout: directed scenarios and
//               randomized traffic compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shop_checkout;

  localparam int SUBMAX  = 4095;
  localparam int SUMMAX  = 65535;
  localparam int CNTMAX  = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       add;
  logic       void_item;
  logic       checkout;
  logic [3:0] weight;
  logic [3:0] per;

  logic [7:0]  price,    price2;
  logic [11:0] subtotal;
  logic [7:0]  subtotal2;
  logic [7:0]  items,    items2;
  logic [7:0]  times,    times2;
  logic [15:0] sum,      sum2;
  logic [1:0]  state,    state2;
  logic        ovf,      ovf2;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_price, m_sub, m_items, m_times, m_sum, m_state, m_ovf, m_last, m_vok;
  int m_prev[3];
  int m_arm[3];

  always #5 clk = ~clk;

  shop_checkout dut (
    .clk(clk), .reset(reset), .weight(weight), .per(per), .add(add),
    .void_item(void_item), .checkout(checkout), .clear(clear),
    .price(price), .subtotal(subtotal), .items(items), .times(times),
    .sum(sum), .state(state), .ovf(ovf)
  );

  shop_checkout #(.SUB_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .weight(weight), .per(per), .add(add),
    .void_item(void_item), .checkout(checkout), .clear(clear),
    .price(price2), .subtotal(subtotal2), .items(items2), .times(times2),
    .sum(sum2), .state(state2), .ovf(ovf2)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: one clock of the checkout rules.
  task automatic model_step();
    int  lvl[3];
    bit  e[3];
    int  prod;
    lvl[0] = int'(add);
    lvl[1] = int'(void_item);
    lvl[2] = int'(checkout);
    if (reset) begin
      m_price = 0; m_sub = 0; m_items = 0; m_times = 0; m_sum = 0;
      m_state = 0; m_ovf = 0; m_last = 0; m_vok = 0;
      for (int i = 0; i < 3; i++) begin
        m_prev[i] = 0;
        m_arm[i]  = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        e[i] = (lvl[i] == 1) && (m_prev[i] == 0) && (m_arm[i] == 1);
        m_prev[i] = lvl[i];
        if (lvl[i] == 0) m_arm[i] = 1;
      end
      prod    = int'(weight) * int'(per);
      m_price = prod;
      if (clear) begin
        m_sub = 0; m_items = 0; m_times = 0; m_sum = 0; m_ovf = 0;
        m_vok = 0; m_state = 0;
      end else if (e[2]) begin
        if (m_state == 1) begin
          if (m_sum + m_sub > SUMMAX) begin m_sum = SUMMAX; m_ovf = 1; end
          else m_sum = m_sum + m_sub;
          if (m_times + 1 > CNTMAX) begin m_times = CNTMAX; m_ovf = 1; end
          else m_times = m_times + 1;
          m_state = 2;
        end
      end else if (e[1]) begin
        if (m_state == 1 && m_vok == 1) begin
          m_sub   = (m_sub >= m_last) ? m_sub - m_last : 0;
          m_items = m_items - 1;
          m_vok   = 0;
          if (m_items == 0) m_state = 0;
        end
      end else if (e[0]) begin
        if (m_state != 1) begin
          m_sub   = 0;
          m_items = 0;
        end
        if (m_sub + prod > SUBMAX) begin m_sub = SUBMAX; m_ovf = 1; end
        else m_sub = m_sub + prod;
        if (m_items + 1 > CNTMAX) begin m_items = CNTMAX; m_ovf = 1; end
        else m_items = m_items + 1;
        m_last  = prod;
        m_vok   = 1;
        m_state = 1;
      end
    end
  endtask

  // Advance one clock, update the model and compare everything 1ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("price",    int'(price),    m_price);
    check("subtotal", int'(subtotal), m_sub);
    check("items",    int'(items),    m_items);
    check("times",    int'(times),    m_times);
    check("sum",      int'(sum),      m_sum);
    check("state",    int'(state),    m_state);
    check("ovf",      int'(ovf),      m_ovf);
  endtask

  task automatic idle_inputs();
    reset = 1'b0; clear = 1'b0; add = 1'b0; void_item = 1'b0; checkout = 1'b0;
  endtask

  task automatic add_item(input int w, input int p);
    weight = 4'(w); per = 4'(p);
    add = 1'b1; tick();
    add = 1'b0; tick();
  endtask

  task automatic do_clear();
    clear = 1'b1; tick();
    clear = 1'b0; tick();
  endtask

  initial begin
    idle_inputs();
    weight = 4'd0; per = 4'd0;
    reset = 1'b1;
    tick(); tick();
    check("rst_state", int'(state), 0);
    check("rst_price", int'(price), 0);
    reset = 1'b0;
    tick();

    // Two items then checkout
    add_item(3, 4);
    add_item(2, 5);
    checkout = 1'b1; tick(); checkout = 1'b0; tick();
    check("t1_subtotal", int'(subtotal), 22);
    check("t1_items",    int'(items),    2);
    check("t1_sum",      int'(sum),      22);
    check("t1_times",    int'(times),    1);
    check("t1_state",    int'(state),    2);

    // One-level undo
    do_clear();
    add_item(3, 4);
    add_item(2, 5);
    void_item = 1'b1; tick(); void_item = 1'b0; tick();
    check("t2_sub_v1",   int'(subtotal), 12);
    check("t2_items_v1", int'(items),    1);
    void_item = 1'b1; tick(); void_item = 1'b0; tick();
    check("t2_sub_v2",   int'(subtotal), 12);
    check("t2_items_v2", int'(items),    1);

    // Held add acts once; repeated checkout counts once
    do_clear();
    weight = 4'd3; per = 4'd4; add = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    add = 1'b0; tick();
    check("t3_items", int'(items),    1);
    check("t3_sub",   int'(subtotal), 12);
    checkout = 1'b1; tick(); checkout = 1'b0; tick();
    checkout = 1'b1; tick(); checkout = 1'b0; tick();
    check("t3_times", int'(times), 1);

    // Simultaneous add/void/checkout in OPEN: checkout only
    do_clear();
    add_item(3, 4);
    weight = 4'd2; per = 4'd5;
    add = 1'b1; void_item = 1'b1; checkout = 1'b1; tick();
    idle_inputs(); tick();
    check("t4_state", int'(state),    2);
    check("t4_items", int'(items),    1);
    check("t4_sub",   int'(subtotal), 12);
    check("t4_sum",   int'(sum),      12);

    // Saturation on the 8-bit subtotal instance, then clear
    do_clear();
    add_item(15, 15);
    add_item(15, 15);
    check("t5_sub8",  int'(subtotal2), 255);
    check("t5_ovf8",  int'(ovf2),      1);
    check("t5_sub12", int'(subtotal),  450);
    clear = 1'b1; tick(); clear = 1'b0;
    check("t5_clr_sub8",   int'(subtotal2), 0);
    check("t5_clr_ovf8",   int'(ovf2),      0);
    check("t5_clr_items8", int'(items2),    0);
    check("t5_clr_state8", int'(state2),    0);
    tick();

    // Reset mid-transaction with add held
    add_item(3, 4);
    add = 1'b1; reset = 1'b1; tick(); tick();
    check("t6_rst_price", int'(price), 0);
    reset = 1'b0;
    tick(); tick(); tick();
    check("t6_items", int'(items),    0);
    check("t6_state", int'(state),    0);
    check("t6_sub",   int'(subtotal), 0);
    add = 1'b0; tick();
    add = 1'b1; tick();
    check("t6_items_after", int'(items), 1);
    add = 1'b0; tick();

    // Random traffic, busy mix
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 399) == 0);
      clear     = ($urandom_range(0, 99) == 0);
      add       = 1'($urandom_range(0, 1));
      void_item = ($urandom_range(0, 4) == 0);
      checkout  = ($urandom_range(0, 9) == 0);
      weight    = 4'($urandom);
      per       = 4'($urandom);
      tick();
    end

    // Random traffic, long transactions to reach saturation
    for (int n = 0; n < 3000; n++) begin
      reset     = 1'b0;
      clear     = ($urandom_range(0, 1999) == 0);
      add       = 1'($urandom_range(0, 1));
      void_item = ($urandom_range(0, 9) == 0);
      checkout  = ($urandom_range(0, 59) == 0);
      weight    = 4'($urandom);
      per       = 4'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shop_checkout.md
SHOP_CHECKOUT -- requirements
Module: shop_checkout

Interface
REQ-001 W_WIDTH, 4, width of weight input.
REQ-002 P_WIDTH, 4, width of unit-price input.
REQ-003 SUB_WIDTH, 12, width of transaction subtotal.
REQ-004 SUM_WIDTH, 16, width of grand total.
REQ-005 CNT_WIDTH, 8, width of item and transaction counters.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 weight  input  W_WIDTH  weight of current item.
REQ-009 per  input  P_WIDTH  unit price of current item.
REQ-010 add  input  1  level; rising edge adds current item.
REQ-011 void  input  1  level; rising edge removes last added item.
REQ-012 checkout  input  1  level; rising edge closes transaction.
REQ-013 clear  input  1  level; zeroes grand total and counters.
REQ-014 price  output  W_WIDTH+P_WIDTH  registered weight*per.
REQ-015 subtotal  output  SUB_WIDTH  running total of open or last-closed transaction.
REQ-016 items  output  CNT_WIDTH  items in current transaction.
REQ-017 times  output  CNT_WIDTH  closed transactions since clear.
REQ-018 sum  output  SUM_WIDTH  grand total of closed transactions.
REQ-019 state  output  2  FSM state encoding.
REQ-020 ovf  output  1  sticky saturation flag.

Function
REQ-021 price SHALL equal weight*per (full W_WIDTH+P_WIDTH product) one cycle after inputs, every cycle.
REQ-022 add, void, checkout SHALL act only on a rising edge (input 1, registered previous value 0); held levels SHALL act once.
REQ-023 FSM states SHALL be IDLE=0 (no transaction), OPEN=1 (items accumulating), DONE=2 (transaction closed, subtotal displayed).
REQ-024 add edge in IDLE or DONE: subtotal<=weight*per, items<=1, last<=weight*per, go OPEN; subtotal/items of previous transaction discarded.
REQ-025 add edge in OPEN: subtotal<=subtotal+weight*per, items<=items+1, last<=weight*per, void_ok<=1.
REQ-026 add SHALL use weight/per of the edge cycle, not the registered price.
REQ-027 void edge in OPEN with void_ok=1: subtotal<=subtotal-last, items<=items-1, void_ok<=0; if items becomes 0, go IDLE.
REQ-028 void edge with void_ok=0, or in IDLE/DONE, SHALL be ignored (one-level undo only).
REQ-029 checkout edge in OPEN: sum<=sum+subtotal, times<=times+1, go DONE; subtotal and items held.
REQ-030 checkout edge in IDLE or DONE SHALL be ignored (no empty or duplicate transaction).
REQ-031 subtotal, sum, items, times SHALL saturate at all-ones; any saturation SHALL set ovf.
REQ-032 A void after a saturated add SHALL subtract last unchanged; subtotal floors at 0.
REQ-033 clear: sum, times, items, subtotal, ovf <= 0, void_ok<=0, go IDLE; price unaffected.
REQ-034 Same-cycle priority: reset > clear > checkout > void > add; lower-priority edges in that cycle SHALL be discarded, not deferred.
REQ-035 Edge-detect registers SHALL update every cycle regardless of which event wins.

Reset
REQ-036 reset SHALL set price, subtotal, items, times, sum, ovf, last, void_ok to 0, state to IDLE, edge registers to 0.
REQ-037 reset mid-transaction SHALL discard the open transaction; inputs held high across reset release SHALL not trigger an edge.

Structure
REQ-038 State encodings and default widths SHALL live in shared package shop_pkg.
REQ-039 Edge detection SHALL be one sub-module, edge_rise (clk, reset, d, pulse), instantiated three times.
REQ-040 Saturating add SHALL be a shared function in shop_pkg, not duplicated.

Verification
REQ-041 weight=3,per=4, add pulse; weight=2,per=5, add pulse; checkout -> subtotal=22, items=2, sum=22, times=1, state DONE.
REQ-042 add (3x4) then add (2x5), void, void -> subtotal=12, items=1 after first void; second void ignored.
REQ-043 add held high 10 cycles with 3x4 -> items=1, subtotal=12; checkout twice -> times=1.
REQ-044 add, checkout, void asserted rising in same cycle in OPEN -> only checkout takes effect.
REQ-045 SUB_WIDTH=8, add 15x15 twice -> subtotal=255, ovf=1; clear -> all zero, ovf=0.
REQ-046 reset during OPEN with add held high -> all outputs 0, IDLE; no add after reset release until add falls and rises.
